// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the
// datapath enables and counts the cycles and retired instructions.
module mc_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic [2:0]  state,
   output logic        pcWrite,
   output logic [1:0]  npcSel,
   output logic        irWrite,
   output logic        regWrite,
   output logic        memWrite,
   output logic [1:0]  regDst,
   output logic [1:0]  wdSel,
   output logic [2:0]  aluOp,
   output logic        aluSrcB,
   output logic        extOp,
   output logic        instrDone,
   output logic [31:0] cycleCnt,
   output logic [31:0] retireCnt
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } stateT;

   typedef enum logic [3:0] {
      CL_NOP  = 4'd0,
      CL_ADDU = 4'd1,
      CL_SUBU = 4'd2,
      CL_JR   = 4'd3,
      CL_ORI  = 4'd4,
      CL_LUI  = 4'd5,
      CL_LW   = 4'd6,
      CL_SW   = 4'd7,
      CL_BEQ  = 4'd8,
      CL_JAL  = 4'd9
   } instrClassT;

   stateT      stateReg;
   stateT      nextState;
   instrClassT classReg;
   instrClassT liveClass;

   assign state = stateReg;

   // Classify the instruction currently held in the IR; only consumed in DECODE
   always_comb begin
      liveClass = CL_NOP;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h21:   liveClass = CL_ADDU;
               6'h23:   liveClass = CL_SUBU;
               6'h08:   liveClass = CL_JR;
               default: liveClass = CL_NOP;
            endcase
         end
         6'h0D:   liveClass = CL_ORI;
         6'h0F:   liveClass = CL_LUI;
         6'h23:   liveClass = CL_LW;
         6'h2B:   liveClass = CL_SW;
         6'h04:   liveClass = CL_BEQ;
         6'h03:   liveClass = CL_JAL;
         default: liveClass = CL_NOP;
      endcase
   end

   // Next-state selection; jumps and NOPs retire in DECODE, so they use the live class
   always_comb begin
      nextState = FETCH;
      case (stateReg)
         FETCH:  nextState = DECODE;
         DECODE: begin
            if (liveClass == CL_JR || liveClass == CL_JAL || liveClass == CL_NOP)
               nextState = FETCH;
            else
               nextState = EXEC;
         end
         EXEC: begin
            case (classReg)
               CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: nextState = WB;
               CL_LW, CL_SW:                     nextState = MEM;
               default:                          nextState = FETCH;
            endcase
         end
         MEM:     nextState = (classReg == CL_LW) ? WB : FETCH;
         WB:      nextState = FETCH;
         default: nextState = FETCH;
      endcase
   end

   // State, latched class and the two free-running counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg  <= FETCH;
         classReg  <= CL_NOP;
         cycleCnt  <= 32'd0;
         retireCnt <= 32'd0;
      end else begin
         stateReg <= nextState;
         if (stateReg == DECODE)
            classReg <= liveClass;
         cycleCnt <= cycleCnt + 32'd1;
         if (instrDone)
            retireCnt <= retireCnt + 32'd1;
      end
   end

   // Datapath controls are decoded from the current state, not registered, because
   // DECODE jumps need the live class and BEQ must follow zero in the same cycle
   always_comb begin
      pcWrite   = 1'b0;
      npcSel    = 2'd0;
      irWrite   = 1'b0;
      regWrite  = 1'b0;
      memWrite  = 1'b0;
      regDst    = 2'd0;
      wdSel     = 2'd0;
      aluOp     = 3'd0;
      aluSrcB   = 1'b0;
      extOp     = 1'b0;
      instrDone = 1'b0;
      if (!reset) begin
         if (stateReg == EXEC || stateReg == MEM || stateReg == WB) begin
            case (classReg)
               CL_SUBU: aluOp = 3'd1;
               CL_ORI:  begin aluOp = 3'd2; aluSrcB = 1'b1; end
               CL_LUI:  begin aluOp = 3'd3; aluSrcB = 1'b1; end
               CL_LW, CL_SW: begin aluOp = 3'd0; aluSrcB = 1'b1; extOp = 1'b1; end
               CL_BEQ:  begin aluOp = 3'd1; extOp = 1'b1; end
               default: aluOp = 3'd0;
            endcase
         end
         case (stateReg)
            FETCH: begin
               irWrite = 1'b1;
               pcWrite = 1'b1;
            end
            DECODE: begin
               case (liveClass)
                  CL_JR: begin
                     pcWrite   = 1'b1;
                     npcSel    = 2'd3;
                     instrDone = 1'b1;
                  end
                  CL_JAL: begin
                     pcWrite   = 1'b1;
                     npcSel    = 2'd2;
                     regWrite  = 1'b1;
                     regDst    = 2'd2;
                     wdSel     = 2'd2;
                     instrDone = 1'b1;
                  end
                  CL_NOP:  instrDone = 1'b1;
                  default: instrDone = 1'b0;
               endcase
            end
            EXEC: begin
               if (classReg == CL_BEQ) begin
                  pcWrite   = zero;
                  npcSel    = 2'd1;
                  instrDone = 1'b1;
               end
            end
            MEM: begin
               if (classReg == CL_SW) begin
                  memWrite  = 1'b1;
                  instrDone = 1'b1;
               end
            end
            WB: begin
               regWrite  = 1'b1;
               instrDone = 1'b1;
               if (classReg == CL_ADDU || classReg == CL_SUBU)
                  regDst = 2'd1;
               if (classReg == CL_LW)
                  wdSel = 2'd1;
            end
            default: instrDone = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl. It runs directed and random instructions
// and compares them against an instruction-level reference model.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opcode = 6'd0;
   logic [5:0]  funct = 6'd0;
   logic        zero = 1'b0;
   logic [2:0]  state;
   logic        pcWrite;
   logic [1:0]  npcSel;
   logic        irWrite;
   logic        regWrite;
   logic        memWrite;
   logic [1:0]  regDst;
   logic [1:0]  wdSel;
   logic [2:0]  aluOp;
   logic        aluSrcB;
   logic        extOp;
   logic        instrDone;
   logic [31:0] cycleCnt;
   logic [31:0] retireCnt;

   localparam int C_NOP = 0, C_ADDU = 1, C_SUBU = 2, C_JR = 3, C_ORI = 4;
   localparam int C_LUI = 5, C_LW = 6, C_SW = 7, C_BEQ = 8, C_JAL = 9;

   int checks = 0;
   int errors = 0;
   logic [31:0] modelCycle = 32'd0;
   logic [31:0] modelRetire = 32'd0;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .state(state), .pcWrite(pcWrite), .npcSel(npcSel), .irWrite(irWrite),
      .regWrite(regWrite), .memWrite(memWrite), .regDst(regDst), .wdSel(wdSel),
      .aluOp(aluOp), .aluSrcB(aluSrcB), .extOp(extOp), .instrDone(instrDone),
      .cycleCnt(cycleCnt), .retireCnt(retireCnt)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Guard against a runaway simulation
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) return (fn == 6'h21) ? C_ADDU : (fn == 6'h23) ? C_SUBU :
                              (fn == 6'h08) ? C_JR : C_NOP;
      if (op == 6'h0D) return C_ORI;
      if (op == 6'h0F) return C_LUI;
      if (op == 6'h23) return C_LW;
      if (op == 6'h2B) return C_SW;
      if (op == 6'h04) return C_BEQ;
      if (op == 6'h03) return C_JAL;
      return C_NOP;
   endfunction

   function automatic int latency(input int cls);
      if (cls == C_JR || cls == C_JAL || cls == C_NOP) return 2;
      if (cls == C_BEQ) return 3;
      if (cls == C_LW) return 5;
      return 4;
   endfunction

   // Phase k of an instruction: FETCH, DECODE, EXEC, then MEM only for memory ops, then WB
   function automatic int stateAt(input int cls, input int k);
      if (k < 3) return k;
      if (k == 3) return (cls == C_LW || cls == C_SW) ? 3 : 4;
      return 4;
   endfunction

   // Expected output vector for one cycle, in the same packing as the DUT probe
   function automatic logic [18:0] expVec(input int cls, input int st, input logic z);
      logic pcW, irW, rW, mW, srcB, ext, done;
      logic [1:0] npc, rd, wd;
      logic [2:0] op;
      pcW = 0; irW = 0; rW = 0; mW = 0; srcB = 0; ext = 0; done = 0;
      npc = 0; rd = 0; wd = 0; op = 0;
      if (st == 0) begin irW = 1; pcW = 1; end
      if (st == 1) begin
         if (cls == C_JR)  begin pcW = 1; npc = 3; done = 1; end
         if (cls == C_JAL) begin pcW = 1; npc = 2; rW = 1; rd = 2; wd = 2; done = 1; end
         if (cls == C_NOP) done = 1;
      end
      if (st >= 2) begin
         if (cls == C_SUBU) op = 1;
         if (cls == C_ORI)  begin op = 2; srcB = 1; end
         if (cls == C_LUI)  begin op = 3; srcB = 1; end
         if (cls == C_LW || cls == C_SW) begin srcB = 1; ext = 1; end
         if (cls == C_BEQ)  begin op = 1; ext = 1; end
      end
      if (st == 2 && cls == C_BEQ) begin pcW = z; npc = 1; done = 1; end
      if (st == 3 && cls == C_SW) begin mW = 1; done = 1; end
      if (st == 4) begin
         rW = 1; done = 1;
         rd = (cls == C_ADDU || cls == C_SUBU) ? 2'd1 : 2'd0;
         wd = (cls == C_LW) ? 2'd1 : 2'd0;
      end
      return {3'(st), pcW, npc, irW, rW, mW, rd, wd, op, srcB, ext, done};
   endfunction

   task automatic applyReset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1;
         #1;
         checkOutput("enablesInReset", {27'd0, pcWrite, irWrite, regWrite, memWrite, instrDone}, 32'd0);
         modelCycle  = 32'd0;
         modelRetire = 32'd0;
      end
   endtask

   // Run one instruction; resetAt >= 0 aborts it with reset in that phase,
   // zeroMode < 0 randomises the ALU flag each cycle
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                input int resetAt, input int zeroMode);
      int cls, lat;
      logic [18:0] ev, dv;
      cls = classify(op, fn);
      lat = latency(cls);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         reset = (k == resetAt);
         if (k == 1) begin
            opcode = op;
            funct  = fn;
         end else begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
         end
         zero = (zeroMode < 0) ? 1'($urandom) : 1'(zeroMode);
         #1;
         if (reset) begin
            checkOutput("enablesInReset", {27'd0, pcWrite, irWrite, regWrite, memWrite, instrDone}, 32'd0);
            modelCycle  = 32'd0;
            modelRetire = 32'd0;
            return;
         end
         dv = {state, pcWrite, npcSel, irWrite, regWrite, memWrite, regDst, wdSel,
               aluOp, aluSrcB, extOp, instrDone};
         ev = expVec(cls, stateAt(cls, k), zero);
         checkOutput($sformatf("op%02h_fn%02h_step%0d_outputs", op, fn, k), {13'd0, dv}, {13'd0, ev});
         checkOutput("cycleCnt", cycleCnt, modelCycle);
         checkOutput("retireCnt", retireCnt, modelRetire);
         modelCycle = modelCycle + 32'd1;
         if (ev[0]) modelRetire = modelRetire + 32'd1;
      end
   endtask

   function automatic logic [5:0] pickOp();
      case ($urandom_range(0, 10))
         0, 1, 2: return 6'h00;
         3:       return 6'h0D;
         4:       return 6'h0F;
         5:       return 6'h23;
         6:       return 6'h2B;
         7:       return 6'h04;
         8:       return 6'h03;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [5:0] pickFunct();
      case ($urandom_range(0, 3))
         0:       return 6'h21;
         1:       return 6'h23;
         2:       return 6'h08;
         default: return 6'($urandom);
      endcase
   endfunction

   // Directed scenarios first, then a random instruction stream with occasional resets
   initial begin
      logic [5:0] rop, rfn;
      int rat;
      applyReset(2);
      applyStimulus(6'h00, 6'h21, -1, -1);
      applyStimulus(6'h23, 6'h00, -1, -1);
      applyStimulus(6'h2B, 6'h00, -1, -1);
      applyStimulus(6'h04, 6'h00, -1, 1);
      applyStimulus(6'h04, 6'h00, -1, 0);
      applyStimulus(6'h03, 6'h00, -1, -1);
      applyStimulus(6'h00, 6'h08, -1, -1);
      applyStimulus(6'h3F, 6'h00, -1, -1);
      applyStimulus(6'h00, 6'h23, -1, -1);
      applyStimulus(6'h0D, 6'h00, -1, -1);
      applyStimulus(6'h0F, 6'h00, -1, -1);
      applyStimulus(6'h23, 6'h00, 3, -1);
      applyStimulus(6'h00, 6'h21, -1, -1);
      for (int i = 0; i < 300; i++) begin
         rop = pickOp();
         rfn = pickFunct();
         rat = ($urandom_range(0, 19) == 0) ?
               int'($urandom_range(0, latency(classify(rop, rfn)) - 1)) : -1;
         applyStimulus(rop, rfn, rat, -1);
      end
      applyStimulus(6'h00, 6'h21, -1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 opcode  in  6  instr[31:26] from instruction register; funct  in  6  instr[5:0].
REQ-003 zero  in  1  ALU equality flag, valid in EXEC.
REQ-004 state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-005 pcWrite  out  1  PC register load enable.
REQ-006 npcSel  out  2  next-PC source: 0=pc+4, 1=branch offset, 2=jal target, 3=jr register.
REQ-007 irWrite  out  1  instruction register load enable.
REQ-008 regWrite  out  1  GRF write enable; memWrite  out  1  DM write enable.
REQ-009 regDst  out  2  0=rt, 1=rd, 2=$31.
REQ-010 wdSel  out  2  0=ALU result, 1=DM data, 2=pc+4.
REQ-011 aluOp  out  3  0=add, 1=sub, 2=or, 3=lui-shift; aluSrcB  out  1  0=rt, 1=imm; extOp  out  1  1=sign-extend.
REQ-012 instrDone  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-013 cycleCnt  out  32  total cycles since reset; retireCnt  out  32  instructions completed since reset.

Function
REQ-014 Decode classes: R(op=0): funct 0x21=ADDU, 0x23=SUBU, 0x08=JR, others=NOP; op 0x0D=ORI, 0x0F=LUI, 0x23=LW, 0x2B=SW, 0x04=BEQ, 0x03=JAL; other op=NOP.
REQ-015 Class is decoded from opcode/funct in DECODE and latched into an internal class register; EXEC/MEM/WB use only the latched class.
REQ-016 FETCH: irWrite=1, pcWrite=1, npcSel=0; next DECODE unconditionally.
REQ-017 DECODE, class JR: pcWrite=1, npcSel=3, instrDone=1; next FETCH.
REQ-018 DECODE, class JAL: pcWrite=1, npcSel=2, regWrite=1, regDst=2, wdSel=2, instrDone=1; next FETCH.
REQ-019 DECODE, class NOP: no write enables, instrDone=1; next FETCH.
REQ-020 DECODE, all other classes: no write enables; next EXEC.
REQ-021 EXEC: ADDU aluOp=0 aluSrcB=0; SUBU aluOp=1 aluSrcB=0; ORI aluOp=2 aluSrcB=1 extOp=0; LUI aluOp=3 aluSrcB=1; LW/SW aluOp=0 aluSrcB=1 extOp=1; BEQ aluOp=1 aluSrcB=0 extOp=1.
REQ-022 EXEC next: ADDU/SUBU/ORI/LUI -> WB; LW/SW -> MEM; BEQ -> FETCH with instrDone=1.
REQ-023 EXEC, BEQ: pcWrite=zero (combinational, same cycle), npcSel=1; zero=0 leaves PC at pc+4 already loaded in FETCH.
REQ-024 MEM, SW: memWrite=1, instrDone=1, next FETCH; MEM, LW: no writes, next WB.
REQ-025 WB: regWrite=1; regDst=1 and wdSel=0 for ADDU/SUBU; regDst=0, wdSel=0 for ORI/LUI; regDst=0, wdSel=1 for LW; instrDone=1; next FETCH.
REQ-026 aluOp/aluSrcB/extOp hold their EXEC values through MEM and WB for the same class; in FETCH/DECODE they are 0.
REQ-027 Outputs not listed for a state are 0; regWrite, memWrite, pcWrite never assert in the same cycle as irWrite except pcWrite in FETCH.
REQ-028 Illegal state encodings (5-7) go to FETCH next cycle with all write enables 0.
REQ-029 cycleCnt increments every non-reset cycle; retireCnt increments on each cycle with instrDone=1; both wrap 0xFFFFFFFF -> 0.
REQ-030 Latencies in cycles: JR/JAL/NOP 2, BEQ 3, SW 4, ADDU/SUBU/ORI/LUI 4, LW 5.

Reset
REQ-031 While reset=1: all write enables and instrDone forced 0 regardless of state.
REQ-032 Next edge after reset sampled high: state=FETCH, class=NOP, cycleCnt=0, retireCnt=0.
REQ-033 Reset asserted mid-instruction (any state) aborts it with no further write enables and no retireCnt increment.

Verification
REQ-034 Reset, then ADDU (op 0, funct 0x21) -> states 0,1,2,4; regWrite=1 regDst=1 in WB; retireCnt=1 at cycle 4.
REQ-035 LW then SW -> LW 5 cycles with wdSel=1 regWrite in WB; SW memWrite=1 in MEM only; retireCnt=2 after 9 cycles.
REQ-036 BEQ with zero=1 in EXEC -> pcWrite=1 npcSel=1 in EXEC; with zero=0 -> pcWrite=0 in EXEC; both 3 cycles.
REQ-037 JAL then JR -> each 2 cycles; JAL DECODE shows regWrite=1 regDst=2 wdSel=2 npcSel=2; JR shows npcSel=3, regWrite=0.
REQ-038 Undefined opcode 0x3F -> NOP, 2 cycles, no writes except FETCH pcWrite/irWrite; reset asserted in MEM of LW -> no WB regWrite, state=0, counters=0.
